// File: rtl/result_alarm_monitor_if.sv
// Result bus from the shared-multiplier equation datapath: one valid word per
// cycle, tagged altitude (sel 0) or battery (sel 1).
interface result_alarm_monitor_if;
  logic        res_valid;
  logic        res_sel;
  logic [15:0] res_data;

  modport master (output res_valid, output res_sel, output res_data);
  modport slave  (input  res_valid, input  res_sel, input  res_data);
endinterface

// File: rtl/result_alarm_monitor.sv
// Per-channel 4-sample moving average with debounced, hysteretic alarms and a
// sticky A/B alternation check on the incoming result stream.
//   state    | meaning
//   OK       | no alarm, no pending violations
//   PEND_SET | violations seen, fewer than DEBOUNCE in a row
//   ALARM    | alarm asserted
//   PEND_CLR | alarm still asserted, clear samples being counted
module result_alarm_monitor #(
  parameter int ALT_LIMIT   = 500,
  parameter int ALT_HYST    = 50,
  parameter int BATT_LOW_TH = 100,
  parameter int BATT_HYST   = 20,
  parameter int DEBOUNCE    = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  result_alarm_monitor_if.slave        res_if,
  output logic [15:0]                  alt_avg_o,
  output logic [15:0]                  batt_avg_o,
  output logic                         avg_valid_o,
  output logic                         avg_sel_o,
  output logic                         alt_alarm_o,
  output logic                         batt_alarm_o,
  output logic                         seq_err_o,
  output logic [7:0]                   sample_count_o
);

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_PEND_SET = 2'd1;
  localparam logic [1:0] ST_ALARM    = 2'd2;
  localparam logic [1:0] ST_PEND_CLR = 2'd3;

  localparam logic [3:0]        DEB      = 4'(DEBOUNCE);
  localparam logic signed [16:0] ALT_SET  = 17'(ALT_LIMIT);
  localparam logic signed [16:0] ALT_CLR  = 17'(ALT_LIMIT - ALT_HYST);
  localparam logic signed [15:0] BATT_SET = 16'(BATT_LOW_TH);
  localparam logic signed [15:0] BATT_CLR = 16'(BATT_LOW_TH + BATT_HYST);

  function automatic logic [17:0] sx(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  function automatic logic [5:0] step(input logic [1:0] st, input logic [3:0] cnt,
                                      input logic bad, input logic good);
    logic [1:0] ns;
    logic [3:0] nc;
    logic [3:0] inc;
    ns  = st;
    nc  = cnt;
    inc = cnt + 4'd1;
    case (st)
      ST_OK: if (bad) begin
        ns = (DEB == 4'd1) ? ST_ALARM : ST_PEND_SET;
        nc = (DEB == 4'd1) ? 4'd0 : 4'd1;
      end
      ST_PEND_SET: begin
        if (!bad)            begin ns = ST_OK;    nc = 4'd0; end
        else if (inc == DEB) begin ns = ST_ALARM; nc = 4'd0; end
        else                 nc = inc;
      end
      ST_ALARM: if (good) begin
        ns = (DEB == 4'd1) ? ST_OK : ST_PEND_CLR;
        nc = (DEB == 4'd1) ? 4'd0 : 4'd1;
      end
      default: begin
        if (!good)           begin ns = ST_ALARM; nc = 4'd0; end
        else if (inc == DEB) begin ns = ST_OK;    nc = 4'd0; end
        else                 nc = inc;
      end
    endcase
    return {ns, nc};
  endfunction

  // Only the three previous samples are stored; the incoming word is the fourth.
  logic [2:0][15:0] alt_hist_q, batt_hist_q, hist_sel;
  logic [17:0]      sum;
  logic [15:0]      avg_new;
  logic [15:0]      alt_avg_q, batt_avg_q;
  logic             avg_valid_q, avg_sel_q;
  logic             last_vld_q, last_sel_q, seq_err_q;
  logic [7:0]       count_q;

  always_comb begin
    hist_sel = res_if.res_sel ? batt_hist_q : alt_hist_q;
    sum      = sx(res_if.res_data) + sx(hist_sel[0]) + sx(hist_sel[1]) + sx(hist_sel[2]);
    avg_new  = sum[17:2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alt_hist_q  <= '0;
      batt_hist_q <= '0;
      alt_avg_q   <= '0;
      batt_avg_q  <= '0;
      avg_valid_q <= 1'b0;
      avg_sel_q   <= 1'b0;
      last_vld_q  <= 1'b0;
      last_sel_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      avg_valid_q <= res_if.res_valid;
      if (res_if.res_valid) begin
        avg_sel_q  <= res_if.res_sel;
        count_q    <= count_q + 8'd1;
        last_vld_q <= 1'b1;
        last_sel_q <= res_if.res_sel;
        if (last_vld_q && (last_sel_q == res_if.res_sel)) seq_err_q <= 1'b1;
        if (res_if.res_sel) begin
          batt_hist_q <= {batt_hist_q[1:0], res_if.res_data};
          batt_avg_q  <= avg_new;
        end else begin
          alt_hist_q <= {alt_hist_q[1:0], res_if.res_data};
          alt_avg_q  <= avg_new;
        end
      end
    end
  end

  logic [1:0]        alt_st_q, alt_st_d, batt_st_q, batt_st_d;
  logic [3:0]        alt_cnt_q, alt_cnt_d, batt_cnt_q, batt_cnt_d;
  logic              alt_alarm_q, batt_alarm_q;
  logic signed [16:0] alt_ext, alt_abs;
  logic              alt_bad, alt_good, batt_bad, batt_good;

  // Magnitude in 17 bits so that -32768 maps to +32768.
  always_comb begin
    alt_ext   = {alt_avg_q[15], alt_avg_q};
    alt_abs   = alt_ext[16] ? -alt_ext : alt_ext;
    alt_bad   = alt_abs > ALT_SET;
    alt_good  = alt_abs <= ALT_CLR;
    batt_bad  = $signed(batt_avg_q) < BATT_SET;
    batt_good = $signed(batt_avg_q) >= BATT_CLR;
    {alt_st_d, alt_cnt_d}   = {alt_st_q, alt_cnt_q};
    {batt_st_d, batt_cnt_d} = {batt_st_q, batt_cnt_q};
    if (avg_valid_q && !avg_sel_q)
      {alt_st_d, alt_cnt_d} = step(alt_st_q, alt_cnt_q, alt_bad, alt_good);
    if (avg_valid_q && avg_sel_q)
      {batt_st_d, batt_cnt_d} = step(batt_st_q, batt_cnt_q, batt_bad, batt_good);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alt_st_q     <= ST_OK;
      batt_st_q    <= ST_OK;
      alt_cnt_q    <= '0;
      batt_cnt_q   <= '0;
      alt_alarm_q  <= 1'b0;
      batt_alarm_q <= 1'b0;
    end else begin
      alt_st_q     <= alt_st_d;
      batt_st_q    <= batt_st_d;
      alt_cnt_q    <= alt_cnt_d;
      batt_cnt_q   <= batt_cnt_d;
      alt_alarm_q  <= (alt_st_d == ST_ALARM) || (alt_st_d == ST_PEND_CLR);
      batt_alarm_q <= (batt_st_d == ST_ALARM) || (batt_st_d == ST_PEND_CLR);
    end
  end

  assign alt_avg_o      = alt_avg_q;
  assign batt_avg_o     = batt_avg_q;
  assign avg_valid_o    = avg_valid_q;
  assign avg_sel_o      = avg_sel_q;
  assign alt_alarm_o    = alt_alarm_q;
  assign batt_alarm_o   = batt_alarm_q;
  assign seq_err_o      = seq_err_q;
  assign sample_count_o = count_q;

endmodule

// File: tb/tb_result_alarm_monitor.sv
// Directed bench for result_alarm_monitor: averaging, debounce/hysteresis,
// extreme values, alternation errors and reset behaviour.
module tb_result_alarm_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alt_avg, batt_avg;
  logic        avg_valid, avg_sel, alt_alarm, batt_alarm, seq_err;
  logic [7:0]  sample_count;
  int          checks = 0;
  int          errors = 0;

  result_alarm_monitor_if bus ();

  result_alarm_monitor dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .res_if         (bus.slave),
    .alt_avg_o      (alt_avg),
    .batt_avg_o     (batt_avg),
    .avg_valid_o    (avg_valid),
    .avg_sel_o      (avg_sel),
    .alt_alarm_o    (alt_alarm),
    .batt_alarm_o   (batt_alarm),
    .seq_err_o      (seq_err),
    .sample_count_o (sample_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_sel   = 1'($urandom_range(0, 1));
    bus.res_data  = 16'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.res_valid = 1'b0;
  endtask

  task automatic send(input logic sel, input logic [15:0] d);
    bus.res_valid = 1'b1;
    bus.res_sel   = sel;
    bus.res_data  = d;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (alt_avg !== 16'd0)     begin errors++; $display("FAIL reset_alt_avg: got %0d expected 0", alt_avg); end
    checks++; if (batt_avg !== 16'd0)    begin errors++; $display("FAIL reset_batt_avg: got %0d expected 0", batt_avg); end
    checks++; if (avg_valid !== 1'b0)    begin errors++; $display("FAIL reset_avg_valid: got %b expected 0", avg_valid); end
    checks++; if (alt_alarm !== 1'b0)    begin errors++; $display("FAIL reset_alt_alarm: got %b expected 0", alt_alarm); end
    checks++; if (batt_alarm !== 1'b0)   begin errors++; $display("FAIL reset_batt_alarm: got %b expected 0", batt_alarm); end
    checks++; if (seq_err !== 1'b0)      begin errors++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    checks++; if (sample_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sample_count); end
  endtask

  task automatic test_averaging();
    logic [15:0] exp_alt [4];
    logic [15:0] exp_batt [4];
    exp_alt  = '{16'd25, 16'd75, 16'd150, 16'd250};
    exp_batt = '{16'd250, 16'd500, 16'd750, 16'd1000};
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 16'(100 * (i + 1)));
      checks++; if (alt_avg !== exp_alt[i]) begin errors++; $display("FAIL avg_alt[%0d]: got %0d expected %0d", i, alt_avg, exp_alt[i]); end
      checks++; if (avg_valid !== 1'b1 || avg_sel !== 1'b0) begin errors++; $display("FAIL avg_pulse_alt[%0d]: got valid=%b sel=%b expected valid=1 sel=0", i, avg_valid, avg_sel); end
      send(1'b1, 16'd1000);
      checks++; if (batt_avg !== exp_batt[i]) begin errors++; $display("FAIL avg_batt[%0d]: got %0d expected %0d", i, batt_avg, exp_batt[i]); end
      checks++; if (avg_valid !== 1'b1 || avg_sel !== 1'b1) begin errors++; $display("FAIL avg_pulse_batt[%0d]: got valid=%b sel=%b expected valid=1 sel=1", i, avg_valid, avg_sel); end
      checks++; if (alt_avg !== exp_alt[i]) begin errors++; $display("FAIL avg_alt_hold[%0d]: got %0d expected %0d", i, alt_avg, exp_alt[i]); end
    end
    idle();
    checks++; if (avg_valid !== 1'b0)    begin errors++; $display("FAIL avg_valid_idle: got %b expected 0", avg_valid); end
    checks++; if (sample_count !== 8'd8) begin errors++; $display("FAIL avg_count: got %0d expected 8", sample_count); end
    checks++; if (seq_err !== 1'b0)      begin errors++; $display("FAIL avg_seq_err: got %b expected 0", seq_err); end
  endtask

  task automatic test_batt_debounce();
    logic [15:0] exp_batt [6];
    logic        exp_alarm [6];
    exp_batt  = '{16'd32, 16'd65, 16'd97, 16'd130, 16'd130, 16'd130};
    exp_alarm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      send(1'b0, 16'd0);
      checks++; if (batt_alarm !== 1'b0) begin errors++; $display("FAIL batt_early_a[%0d]: got %b expected 0", k, batt_alarm); end
      send(1'b1, 16'd0);
      checks++; if (batt_alarm !== 1'b0) begin errors++; $display("FAIL batt_early_b[%0d]: got %b expected 0", k, batt_alarm); end
    end
    send(1'b0, 16'd0);
    checks++; if (batt_alarm !== 1'b1) begin errors++; $display("FAIL batt_set: got %b expected 1", batt_alarm); end
    for (int k = 0; k < 6; k++) begin
      send(1'b1, 16'd130);
      checks++; if (batt_avg !== exp_batt[k]) begin errors++; $display("FAIL batt_clr_avg[%0d]: got %0d expected %0d", k, batt_avg, exp_batt[k]); end
      send(1'b0, 16'd0);
      checks++; if (batt_alarm !== exp_alarm[k]) begin errors++; $display("FAIL batt_clr_alarm[%0d]: got %b expected %b", k, batt_alarm, exp_alarm[k]); end
    end
    checks++; if (alt_alarm !== 1'b0) begin errors++; $display("FAIL batt_alt_quiet: got %b expected 0", alt_alarm); end
  endtask

  task automatic test_alt_extreme();
    logic [15:0] exp_alt [4];
    logic        exp_alarm [4];
    exp_alt   = '{16'hE000, 16'hC000, 16'hA000, 16'h8000};
    exp_alarm = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 16'h8000);
      checks++; if (alt_avg !== exp_alt[i]) begin errors++; $display("FAIL alt_ext_avg[%0d]: got %0d expected %0d", i, $signed(alt_avg), $signed(exp_alt[i])); end
      send(1'b1, 16'd1000);
      checks++; if (alt_alarm !== exp_alarm[i]) begin errors++; $display("FAIL alt_ext_alarm[%0d]: got %b expected %b", i, alt_alarm, exp_alarm[i]); end
    end
    idle();
    checks++; if (alt_alarm !== 1'b1)  begin errors++; $display("FAIL alt_ext_hold: got %b expected 1", alt_alarm); end
    checks++; if (batt_alarm !== 1'b0) begin errors++; $display("FAIL alt_ext_batt: got %b expected 0", batt_alarm); end
  endtask

  task automatic test_seq_err();
    do_reset(1);
    send(1'b0, 16'd10);
    send(1'b1, 16'd20);
    send(1'b0, 16'd30);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_before: got %b expected 0", seq_err); end
    checks++; if (alt_avg !== 16'd10) begin errors++; $display("FAIL seq_alt_pre: got %0d expected 10", alt_avg); end
    send(1'b0, 16'd50);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_set: got %b expected 1", seq_err); end
    checks++; if (alt_avg !== 16'd22) begin errors++; $display("FAIL seq_alt_avg: got %0d expected 22", alt_avg); end
    send(1'b1, 16'd40);
    idle();
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b expected 1", seq_err); end
    checks++; if (batt_avg !== 16'd15) begin errors++; $display("FAIL seq_batt_avg: got %0d expected 15", batt_avg); end
    checks++; if (sample_count !== 8'd5) begin errors++; $display("FAIL seq_count: got %0d expected 5", sample_count); end
  endtask

  task automatic test_reset_mid_pending();
    do_reset(1);
    send(1'b0, 16'd0);
    send(1'b1, 16'd0);
    send(1'b0, 16'd0);
    send(1'b1, 16'd0);
    idle();
    do_reset(1);
    checks++; if (seq_err !== 1'b0 || sample_count !== 8'd0) begin errors++; $display("FAIL rmp_reset: got seq_err=%b count=%0d expected 0 0", seq_err, sample_count); end
    send(1'b0, 16'd0);
    send(1'b1, 16'd0);
    send(1'b0, 16'd0);
    checks++; if (batt_alarm !== 1'b0) begin errors++; $display("FAIL rmp_after1: got %b expected 0", batt_alarm); end
    send(1'b1, 16'd0);
    send(1'b0, 16'd0);
    checks++; if (batt_alarm !== 1'b0) begin errors++; $display("FAIL rmp_after2: got %b expected 0", batt_alarm); end
    send(1'b1, 16'd0);
    send(1'b0, 16'd0);
    checks++; if (batt_alarm !== 1'b1) begin errors++; $display("FAIL rmp_after3: got %b expected 1", batt_alarm); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rmp_first_sample: got %b expected 0", seq_err); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_sel   = 1'b0;
    bus.res_data  = 16'd0;
    test_reset();
    test_averaging();
    test_batt_debounce();
    test_alt_extreme();
    test_seq_err();
    test_reset_mid_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_alarm_monitor.md
Name: result_alarm_monitor

Overview:
- Downstream consumer of the shared-multiplier equation datapath.
- Receives the time-multiplexed results: altitude correction A (sel 0) and battery estimate B (sel 1).
- Keeps a 4-sample moving average per channel.
- Raises debounced, hysteretic alarms: altitude out of range, battery low.
- Flags any break in the A/B alternation protocol.

Parameters:
- ALT_LIMIT, 500: altitude alarm asserts when |alt_avg| > ALT_LIMIT.
- ALT_HYST, 50: altitude alarm clears when |alt_avg| <= ALT_LIMIT - ALT_HYST.
- BATT_LOW_TH, 100: battery alarm asserts when batt_avg < BATT_LOW_TH.
- BATT_HYST, 20: battery alarm clears when batt_avg >= BATT_LOW_TH + BATT_HYST.
- DEBOUNCE, 3: consecutive same-channel qualifying samples needed to set or clear an alarm. Range 1..15.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- res_valid, input, 1: res_data is valid this cycle.
- res_sel, input, 1: 0 = altitude result, 1 = battery result.
- res_data, input, 16: signed result.
- alt_avg, output, 16: signed altitude moving average.
- batt_avg, output, 16: signed battery moving average.
- avg_valid, output, 1: one-cycle pulse when either average updates.
- avg_sel, output, 1: channel updated on the avg_valid cycle.
- alt_alarm, output, 1: altitude alarm.
- batt_alarm, output, 1: battery-low alarm.
- seq_err, output, 1: sticky alternation error.
- sample_count, output, 8: accepted samples, wraps 255 -> 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All outputs 0.
  - Both 4-deep sample windows cleared to 0.
  - Debounce counters 0; both FSMs in OK; "last sel" invalid.
  - rst overrides a simultaneous res_valid; that sample is dropped.
- Acceptance: a sample is accepted at edge T when res_valid=1. No backpressure; every valid sample is accepted.
- Window update for the channel selected by res_sel:
  - Window shifts in res_data and drops the oldest entry.
  - Sum is 18-bit signed.
  - avg = sum >>> 2 (arithmetic shift, floor toward -inf), truncated to 16 bits. The result is always representable.
  - Average register and avg_valid/avg_sel update at edge T (latency 1).
  - Before 4 samples, the empty slots count as 0 (e.g. the first sample 100 gives avg 25).
  - The other channel's average holds.
- sample_count increments by 1 on every accepted sample.
- Sequence check:
  - seq_err sets if an accepted sample has the same res_sel as the previous accepted sample.
  - Cleared only by rst.
  - The offending sample is still processed normally.
  - The first sample after reset never errors.
- Alarm FSM, one per channel, evaluated at edge T+1 only when avg_valid=1 and avg_sel matches the channel; the registered average is used.
  - Violation: altitude |alt_avg| > ALT_LIMIT; battery batt_avg < BATT_LOW_TH. Compute |.| in 17 bits so -32768 gives 32768.
  - Clear condition: as defined in Parameters.
  - States: OK, PEND_SET, ALARM, PEND_CLR.
  - OK: violation -> cnt=1; go to ALARM if DEBOUNCE=1, else PEND_SET. Otherwise stay.
  - PEND_SET: violation -> cnt+1; if cnt+1 == DEBOUNCE, go to ALARM and cnt=0. Non-violation -> OK, cnt=0.
  - ALARM: clear condition -> cnt=1; go to OK if DEBOUNCE=1, else PEND_CLR. Otherwise stay.
  - PEND_CLR: clear condition -> cnt+1; at DEBOUNCE go to OK, cnt=0. Non-clear -> ALARM, cnt=0.
  - Samples inside the hysteresis band count as neither violation nor clear. They reset a pending count per the rules above.
- Alarm outputs:
  - alarm = (state == ALARM) || (state == PEND_CLR), registered.
  - Visible after edge T+1, i.e. 2 cycles after the triggering sample.
- Back-to-back samples on consecutive cycles are supported with full throughput. Window and FSM stages pipeline independently.

Test Plan:
- Reset: hold rst 3 cycles with res_valid=1 and random data -> all outputs 0, sample_count=0, seq_err=0.
- Averaging: alternate A=100,200,300,400 with B=1000 x4 -> alt_avg 25,75,150,250; batt_avg 250,500,750,1000; avg_valid pulses 8 times; sample_count=8.
- Battery debounce: from reset, alternate A=0 and B=0 -> batt_alarm rises 2 cycles after the 3rd B sample and not earlier. Then send B=130 six times -> batt_avg 32,65,97,130,130,130; batt_alarm falls after the 6th.
- Altitude extreme: alternate A=-32768 with B=1000 -> alt_avg -8192,-16384,-24576,-32768; alt_alarm set after the 3rd A sample; batt_alarm stays 0.
- Sequence error: A,B,A,A,B -> seq_err rises at the 2nd consecutive A, stays 1; that A is still averaged.
- Reset mid-pending: two violating B samples (PEND_SET, cnt=2), then rst, then one violating B -> no alarm until 2 more violating B samples (3 total after reset).
